// File: rtl/ahb_uart.sv
// ahb_uart: AHB-Lite slave UART (8N1) with a TX FIFO and a programmable baud divider.
// Define UART_RX_EN to build the receiver, the RX FIFO, the RX status bits and IRQ.
module ahb_uart_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       CLK,
    input  logic       reset_n,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    output logic       o_full,
    output logic       o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [CW-1:0] r_cnt;
    logic          w_push, w_pop;
    assign o_full  = r_cnt == CW'(DEPTH);
    assign o_empty = r_cnt == '0;
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_data  = r_mem[r_rp];
    always_ff @(posedge CLK or negedge reset_n)
        if (!reset_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    always_ff @(posedge CLK)
        if (w_push) r_mem[r_wp] <= i_data;
endmodule

module ahb_uart #(
    parameter int FIFO_DEPTH  = 16,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 434
) (
    input  logic        CLK,
    input  logic        reset_n,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    input  logic        RsRx,
    output logic        RsTx,
    output logic        IRQ
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    logic             r_act, r_wr;
    logic [1:0]       r_addr;
    logic [DIV_W-1:0] r_div, w_div;
    logic             w_wr, w_rd, w_tx_push, w_st_wr;
    logic             r_tx_ovr, w_rx_ovr, w_ferr, w_rx_full, w_rx_empty;
    logic [7:0]       w_rx_q;
    logic             w_unused;
    assign w_unused  = &{1'b0, HADDR, HTRANS[0], HWDATA, RsRx};
    assign HREADYOUT = 1'b1;
    assign w_wr      = r_act & r_wr;
    assign w_rd      = r_act & ~r_wr;
    assign w_tx_push = w_wr & (r_addr == 2'd0);
    assign w_st_wr   = w_wr & (r_addr == 2'd1);
    assign w_div     = (r_div < DIV_W'(2)) ? DIV_W'(2) : r_div;
    always_ff @(posedge CLK or negedge reset_n)
        if (!reset_n) begin
            r_act  <= 1'b0;
            r_wr   <= 1'b0;
            r_addr <= '0;
            r_div  <= DIV_W'(DEFAULT_DIV);
        end else begin
            r_act  <= HSEL & HREADY & HTRANS[1];
            r_wr   <= HWRITE;
            r_addr <= HADDR[3:2];
            if (w_wr && r_addr == 2'd2) r_div <= HWDATA[DIV_W-1:0];
        end
    // Transmitter
    state_t           r_tx_st, w_tx_nx;
    logic [DIV_W-1:0] r_tx_cnt;
    logic [7:0]       r_tx_sh, w_tx_q;
    logic [2:0]       r_tx_bit;
    logic             r_tx, w_tx_pop, w_tx_full, w_tx_empty, w_tx_end, w_tx_idle;
    assign w_tx_end  = r_tx_cnt == '0;
    assign w_tx_idle = w_tx_empty & (r_tx_st == IDLE);
    assign RsTx      = r_tx;
    ahb_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .CLK(CLK), .reset_n(reset_n), .i_push(w_tx_push), .i_pop(w_tx_pop),
        .i_data(HWDATA[7:0]), .o_data(w_tx_q), .o_full(w_tx_full), .o_empty(w_tx_empty)
    );
    always_comb begin
        w_tx_nx  = r_tx_st;
        w_tx_pop = 1'b0;
        case (r_tx_st)
            IDLE:  if (!w_tx_empty) begin
                       w_tx_nx  = START;
                       w_tx_pop = 1'b1;
                   end
            START: if (w_tx_end) w_tx_nx = DATA;
            DATA:  if (w_tx_end && r_tx_bit == 3'd7) w_tx_nx = STOP;
            STOP:  if (w_tx_end) begin
                       w_tx_nx  = w_tx_empty ? IDLE : START;
                       w_tx_pop = ~w_tx_empty;
                   end
        endcase
    end
    always_ff @(posedge CLK or negedge reset_n)
        if (!reset_n) begin
            r_tx_st  <= IDLE;
            r_tx_cnt <= '0;
            r_tx_sh  <= '0;
            r_tx_bit <= '0;
            r_tx     <= 1'b1;
            r_tx_ovr <= 1'b0;
        end else begin
            r_tx_st  <= w_tx_nx;
            r_tx     <= (r_tx_st == START) ? 1'b0 : (r_tx_st == DATA) ? r_tx_sh[0] : 1'b1;
            r_tx_ovr <= (w_tx_push & w_tx_full) | (r_tx_ovr & ~(w_st_wr & HWDATA[4]));
            if (w_tx_pop) begin
                r_tx_sh  <= w_tx_q;
                r_tx_cnt <= w_div - 1'b1;
                r_tx_bit <= '0;
            end else if (r_tx_st != IDLE) begin
                if (w_tx_end) begin
                    r_tx_cnt <= w_div - 1'b1;
                    if (r_tx_st == DATA) begin
                        r_tx_sh  <= r_tx_sh >> 1;
                        r_tx_bit <= r_tx_bit + 1'b1;
                    end
                end else r_tx_cnt <= r_tx_cnt - 1'b1;
            end
        end
`ifdef UART_RX_EN
    // Receiver: samples mid-bit, the first check lands half a period into the start bit
    state_t           r_rx_st, w_rx_nx;
    logic [1:0]       r_rx_s;
    logic [DIV_W-1:0] r_rx_cnt;
    logic [7:0]       r_rx_sh;
    logic [2:0]       r_rx_bit;
    logic             r_rx_ovr, r_ferr, w_rx, w_rx_end, w_rx_push, w_rx_pop, w_stop_end;
    assign w_rx       = r_rx_s[1];
    assign w_rx_end   = r_rx_cnt == '0;
    assign w_stop_end = (r_rx_st == STOP) & w_rx_end;
    assign w_rx_push  = w_stop_end & w_rx;
    assign w_rx_pop   = w_rd & (r_addr == 2'd0) & ~w_rx_empty;
    assign w_rx_ovr   = r_rx_ovr;
    assign w_ferr     = r_ferr;
    assign IRQ        = ~w_rx_empty;
    ahb_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .CLK(CLK), .reset_n(reset_n), .i_push(w_rx_push), .i_pop(w_rx_pop),
        .i_data(r_rx_sh), .o_data(w_rx_q), .o_full(w_rx_full), .o_empty(w_rx_empty)
    );
    always_comb begin
        w_rx_nx = r_rx_st;
        case (r_rx_st)
            IDLE:  if (!w_rx) w_rx_nx = START;
            START: if (w_rx_end) w_rx_nx = w_rx ? IDLE : DATA;
            DATA:  if (w_rx_end && r_rx_bit == 3'd7) w_rx_nx = STOP;
            STOP:  if (w_rx_end) w_rx_nx = IDLE;
        endcase
    end
    always_ff @(posedge CLK or negedge reset_n)
        if (!reset_n) begin
            r_rx_s   <= 2'b11;
            r_rx_st  <= IDLE;
            r_rx_cnt <= '0;
            r_rx_sh  <= '0;
            r_rx_bit <= '0;
            r_rx_ovr <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_rx_s   <= {r_rx_s[0], RsRx};
            r_rx_st  <= w_rx_nx;
            r_rx_ovr <= (w_rx_push & w_rx_full) | (r_rx_ovr & ~(w_st_wr & HWDATA[5]));
            r_ferr   <= (w_stop_end & ~w_rx) | (r_ferr & ~(w_st_wr & HWDATA[6]));
            if (r_rx_st == IDLE) begin
                r_rx_cnt <= (w_div >> 1) - 1'b1;
                r_rx_bit <= '0;
            end else if (w_rx_end) begin
                r_rx_cnt <= w_div - 1'b1;
                if (r_rx_st == DATA) begin
                    r_rx_sh  <= {w_rx, r_rx_sh[7:1]};
                    r_rx_bit <= r_rx_bit + 1'b1;
                end
            end else r_rx_cnt <= r_rx_cnt - 1'b1;
        end
`else
    assign w_rx_ovr   = 1'b0;
    assign w_ferr     = 1'b0;
    assign w_rx_full  = 1'b0;
    assign w_rx_empty = 1'b1;
    assign w_rx_q     = '0;
    assign IRQ        = 1'b0;
`endif
    always_comb begin
        HRDATA = '0;
        if (w_rd)
            HRDATA = (r_addr == 2'd0) ? {24'b0, w_rx_empty ? 8'h00 : w_rx_q} :
                     (r_addr == 2'd1) ? {25'b0, w_ferr, w_rx_ovr, r_tx_ovr, w_rx_full, ~w_rx_empty, w_tx_idle, w_tx_full} :
                     (r_addr == 2'd2) ? 32'(r_div) : 32'h0;
    end
endmodule

// File: tb/tb_ahb_uart.sv
// tb_ahb_uart: directed bench for ahb_uart; RX steps run when UART_RX_EN is defined.
module tb_ahb_uart;
    logic        CLK = 1'b0, reset_n = 1'b0;
    logic        HSEL = 1'b0, HWRITE = 1'b0, HREADY = 1'b1, RsRx = 1'b1;
    logic [31:0] HADDR = '0, HWDATA = '0;
    logic [1:0]  HTRANS = '0;
    logic [31:0] HRDATA;
    logic        HREADYOUT, RsTx, IRQ;
    int          checks = 0, errors = 0;
    logic [31:0] rd;

    ahb_uart dut (
        .CLK(CLK), .reset_n(reset_n), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA),
        .HREADYOUT(HREADYOUT), .RsRx(RsRx), .RsTx(RsTx), .IRQ(IRQ)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(posedge CLK) #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {28'h0, a};
        @(posedge CLK) #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
        @(posedge CLK) #1;
    endtask

    task automatic rdreg(input logic [3:0] a, output logic [31:0] d);
        @(posedge CLK) #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {28'h0, a};
        @(posedge CLK) #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        @(negedge CLK);
        d = HRDATA;
    endtask

    task automatic send(input logic [7:0] b, input logic stp, input int div);
        logic [9:0] f;
        f = {stp, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK) #1;
            RsRx = f[i];
            repeat (div - 1) @(posedge CLK);
        end
        @(posedge CLK) #1;
        RsRx = 1'b1;
        repeat (div) @(posedge CLK);
    endtask

    initial begin
        logic [7:0] tx_byte;
        #22 reset_n = 1'b1;
        @(negedge CLK);
        chk("reset_rstx", 32'(RsTx), 32'h1);
        chk("reset_irq", 32'(IRQ), 32'h0);
        chk("reset_hrdata", HRDATA, 32'h0);
        chk("reset_hreadyout", 32'(HREADYOUT), 32'h1);
        rdreg(4'h4, rd); chk("reset_status", rd, 32'h2);
        rdreg(4'h8, rd); chk("reset_bauddiv", rd, 32'd434);
        rdreg(4'hC, rd); chk("reg_c_read", rd, 32'h0);

        // 0x55 at 4 clocks per bit
        wr(4'h8, 32'd4);
        rdreg(4'h8, rd); chk("bauddiv_rw", rd, 32'd4);
        tx_byte = 8'h55;
        wr(4'h0, 32'h55);
        @(negedge CLK); chk("tx_lat_n", 32'(RsTx), 32'h1);
        @(negedge CLK); chk("tx_lat_n1", 32'(RsTx), 32'h1);
        for (int b = 0; b < 10; b++)
            for (int c = 0; c < 4; c++) begin
                @(negedge CLK);
                chk($sformatf("tx_bit%0d", b), 32'(RsTx),
                    (b == 0) ? 32'h0 : (b == 9) ? 32'h1 : 32'(tx_byte[b-1]));
            end
        rdreg(4'h4, rd); chk("tx_idle_after", rd, 32'h2);

        // TX overrun
        wr(4'h8, 32'd1000);
        for (int i = 0; i < 18; i++) wr(4'h0, 32'(i));
        rdreg(4'h4, rd); chk("tx_full_ovr", rd, 32'h11);
        wr(4'h4, 32'h10);
        rdreg(4'h4, rd); chk("tx_ovr_clear", rd, 32'h1);
        rdreg(4'h0, rd); chk("data_read_empty", rd, 32'h0);

        @(posedge CLK) #1 reset_n = 1'b0;
        #1 chk("reset_clears_tx", 32'(RsTx), 32'h1);
        repeat (2) @(posedge CLK);
        @(negedge CLK) reset_n = 1'b1;
        rdreg(4'h4, rd); chk("status_after_reset1", rd, 32'h2);

        // Reset during a data bit
        wr(4'h8, 32'd4);
        wr(4'h0, 32'h00);
        repeat (10) @(negedge CLK);
        chk("tx_data_bit_low", 32'(RsTx), 32'h0);
        #1 reset_n = 1'b0;
        #1 chk("tx_reset_async", 32'(RsTx), 32'h1);
        repeat (2) @(posedge CLK);
        @(negedge CLK) reset_n = 1'b1;
        rdreg(4'h4, rd); chk("status_after_reset2", rd, 32'h2);
        rdreg(4'h8, rd); chk("bauddiv_after_reset", rd, 32'd434);
        repeat (20) @(negedge CLK);
        chk("no_resume", 32'(RsTx), 32'h1);

        wr(4'h8, 32'd8);
`ifdef UART_RX_EN
        send(8'hA3, 1'b1, 8);
        chk("rx_irq", 32'(IRQ), 32'h1);
        rdreg(4'h4, rd); chk("rx_status", rd, 32'h6);
        rdreg(4'h0, rd); chk("rx_data", rd, 32'hA3);
        @(negedge CLK); chk("rx_irq_clear", 32'(IRQ), 32'h0);

        send(8'h3C, 1'b0, 8);
        rdreg(4'h4, rd); chk("rx_frame_err", rd, 32'h42);
        chk("rx_ferr_no_irq", 32'(IRQ), 32'h0);
        wr(4'h4, 32'h40);
        rdreg(4'h4, rd); chk("rx_ferr_clear", rd, 32'h2);

        @(posedge CLK) #1 RsRx = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RsRx = 1'b1;
        repeat (30) @(posedge CLK);
        rdreg(4'h4, rd); chk("rx_glitch", rd, 32'h2);
        chk("rx_glitch_irq", 32'(IRQ), 32'h0);

        for (int i = 0; i < 17; i++) send(8'(i * 7 + 1), 1'b1, 8);
        rdreg(4'h4, rd); chk("rx_full_ovr", rd, 32'h2E);
        for (int i = 0; i < 16; i++) begin
            rdreg(4'h0, rd);
            chk($sformatf("rx_order%0d", i), rd, 32'(8'(i * 7 + 1)));
        end
        rdreg(4'h4, rd); chk("rx_drained", rd, 32'h22);
`else
        send(8'hA3, 1'b1, 8);
        chk("norx_irq", 32'(IRQ), 32'h0);
        rdreg(4'h4, rd); chk("norx_status", rd, 32'h2);
        rdreg(4'h0, rd); chk("norx_data", rd, 32'h0);
        wr(4'h4, 32'h70);
        rdreg(4'h4, rd); chk("norx_status_clear", rd, 32'h2);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
